// File: rtl/acs_pmu.sv
// acs_pmu: add-compare-select and path-metric unit for a rate-1/2, K=3 (7,5)
// Viterbi decoder. Each accepted symbol updates four path metrics from eight
// branch metrics. It also emits one survivor bit per state, the best state
// index and a normalization pulse. All results are registered with 1-cycle
// latency.
//
// Ports
//   i_clk                 rising-edge clock
//   i_reset               synchronous active-high reset
//   i_in_valid            branch metrics valid this cycle
//   i_frame_start         restart trellis from state 0
//   i_bm0..i_bm7          2-bit branch metrics
//   o_dec_valid           outputs updated by an accepted symbol this cycle
//   o_dec                 survivor bits, bit n = 1 -> odd predecessor won
//   o_pm0..o_pm3          registered path metrics
//   o_best_state          index of smallest metric (lowest index on tie)
//   o_norm_event          normalization applied on this update
module acs_pmu #(
    parameter int PM_W    = 5,
    parameter int PM_INIT = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_in_valid,
    input  logic            i_frame_start,
    input  logic [1:0]      i_bm0,
    input  logic [1:0]      i_bm1,
    input  logic [1:0]      i_bm2,
    input  logic [1:0]      i_bm3,
    input  logic [1:0]      i_bm4,
    input  logic [1:0]      i_bm5,
    input  logic [1:0]      i_bm6,
    input  logic [1:0]      i_bm7,
    output logic            o_dec_valid,
    output logic [3:0]      o_dec,
    output logic [PM_W-1:0] o_pm0,
    output logic [PM_W-1:0] o_pm1,
    output logic [PM_W-1:0] o_pm2,
    output logic [PM_W-1:0] o_pm3,
    output logic [1:0]      o_best_state,
    output logic            o_norm_event
);

    localparam logic [PM_W-1:0] INIT = PM_W'(PM_INIT);
    // Half range: once every survivor is at or above it, all can be shifted
    // down together without changing their relative order.
    localparam logic [PM_W:0]   HALF = {2'b01, {(PM_W-1){1'b0}}};

    logic [PM_W-1:0] r_pm [4];
    logic [3:0]      r_dec;
    logic [1:0]      r_best;
    logic            r_dec_valid;
    logic            r_norm;

    logic [PM_W-1:0] w_old  [4];
    logic [PM_W:0]   w_even [4];
    logic [PM_W:0]   w_odd  [4];
    logic [PM_W:0]   w_sel  [4];
    logic [PM_W:0]   w_adj  [4];
    logic [PM_W-1:0] w_new  [4];
    logic [3:0]      w_dec;
    logic            w_norm;
    logic [1:0]      w_best;
    logic [PM_W-1:0] w_min;

    function automatic logic [PM_W:0] ext_add(input logic [PM_W-1:0] pm,
                                              input logic [1:0] bm);
        return {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
    endfunction

    always_comb begin
        // frame_start with a symbol runs the ACS from the initial metrics
        w_old[0] = i_frame_start ? '0   : r_pm[0];
        w_old[1] = i_frame_start ? INIT : r_pm[1];
        w_old[2] = i_frame_start ? INIT : r_pm[2];
        w_old[3] = i_frame_start ? INIT : r_pm[3];

        w_even[0] = ext_add(w_old[0], i_bm0);
        w_odd[0]  = ext_add(w_old[1], i_bm1);
        w_even[1] = ext_add(w_old[2], i_bm4);
        w_odd[1]  = ext_add(w_old[3], i_bm5);
        w_even[2] = ext_add(w_old[0], i_bm2);
        w_odd[2]  = ext_add(w_old[1], i_bm3);
        w_even[3] = ext_add(w_old[2], i_bm6);
        w_odd[3]  = ext_add(w_old[3], i_bm7);

        w_norm = 1'b1;
        for (int n = 0; n < 4; n++) begin
            // strict compare: a tie keeps the even predecessor
            w_dec[n] = (w_odd[n] < w_even[n]);
            w_sel[n] = w_dec[n] ? w_odd[n] : w_even[n];
            if (w_sel[n] < HALF) w_norm = 1'b0;
        end

        for (int n = 0; n < 4; n++) begin
            w_adj[n] = w_norm ? (w_sel[n] - HALF) : w_sel[n];
            w_new[n] = w_adj[n][PM_W-1:0];
        end

        w_best = 2'd0;
        w_min  = w_new[0];
        for (int n = 1; n < 4; n++) begin
            if (w_new[n] < w_min) begin
                w_min  = w_new[n];
                w_best = 2'(n);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pm[0]     <= '0;
            r_pm[1]     <= INIT;
            r_pm[2]     <= INIT;
            r_pm[3]     <= INIT;
            r_dec       <= '0;
            r_best      <= '0;
            r_dec_valid <= 1'b0;
            r_norm      <= 1'b0;
        end else if (i_in_valid) begin
            for (int n = 0; n < 4; n++) r_pm[n] <= w_new[n];
            r_dec       <= w_dec;
            r_best      <= w_best;
            r_dec_valid <= 1'b1;
            r_norm      <= w_norm;
        end else begin
            if (i_frame_start) begin
                r_pm[0] <= '0;
                r_pm[1] <= INIT;
                r_pm[2] <= INIT;
                r_pm[3] <= INIT;
            end
            r_dec_valid <= 1'b0;
            r_norm      <= 1'b0;
        end
    end

    // The metric spread of this trellis keeps stored values in range;
    // the dropped carry bit must therefore always be zero.
    always_ff @(posedge i_clk) begin
        if (!i_reset && i_in_valid) begin
            for (int n = 0; n < 4; n++) assert (w_adj[n][PM_W] == 1'b0);
        end
    end

    assign o_pm0        = r_pm[0];
    assign o_pm1        = r_pm[1];
    assign o_pm2        = r_pm[2];
    assign o_pm3        = r_pm[3];
    assign o_dec        = r_dec;
    assign o_best_state = r_best;
    assign o_dec_valid  = r_dec_valid;
    assign o_norm_event = r_norm;

endmodule
